lapido_fetch_unit: RTL and testbench
====================================

Name: lapido_fetch_unit

Overview:
Instruction fetch stage of the LAPI DOpaCA LAMBA pipeline, directly upstream of the decode (ID) stage. It holds the PC and issues word-addressed requests to instruction memory over a req/ack handshake. It loads the IF/ID pipeline register and applies stall, flush and redirect. Redirects come from ID jumps and MEM branches. It detects jump-to-self as halt and stops fetching.

Parameters:
PC_WIDTH, 16, word-address width of PC and memory address
INST_WIDTH, 32, instruction width
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
stall  in  1  ID hazard hold; IF/ID register must not change
mem_branch_taken  in  1  MEM-stage branch resolved taken
mem_branch_addr  in  PC_WIDTH  branch target
id_is_jump  in  1  ID holds a jump
id_jump_addr  in  PC_WIDTH  jump target
imem_req  out  1  fetch request
imem_addr  out  PC_WIDTH  fetch address (registered)
imem_ack  in  1  one-cycle data-valid strobe; only legal while imem_req=1
imem_rdata  in  INST_WIDTH  instruction, valid with ack
id_instruction  out  INST_WIDTH  IF/ID instruction register
id_pc_plus1  out  PC_WIDTH  IF/ID PC+1
id_valid  out  1  IF/ID holds a real instruction
halted  out  1  halt detected, fetch stopped

Behaviour:
- Reset (rst=0, async): state=BOOT, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, id_instruction=0 (NOP), id_pc_plus1=0, id_valid=0, halted=0, skid buffer empty, drop flag clear.
- States: BOOT -> FETCH unconditionally (first cycle after reset release, no request); FETCH -> HALT on halt detect; HALT is left only by reset.
- FETCH: imem_req=1 unless the skid buffer is full. imem_addr and imem_req stay stable from issue until ack; memory latency is variable (>=1 cycle). Back-to-back requests are allowed: after an ack, the next request issues on the following cycle at the new pc.
- Ack, no stall, no redirect, drop clear: id_instruction<=imem_rdata, id_pc_plus1<=imem_addr+1, id_valid<=1, pc<=pc+1. Arithmetic is modulo 2^PC_WIDTH, so 0xFFFF wraps to 0.
- Ack while stall=1: capture the instruction and PC+1 into a 1-entry skid buffer and drop imem_req. The first cycle with stall=0 moves the buffer into IF/ID, and requesting resumes.
- Stall with no new data: IF/ID holds its value and id_valid is unchanged.
- Cycles with stall=0, no ack and an empty buffer: id_valid<=0 (bubble).
- Redirect sources:
  - mem_branch_taken is honoured regardless of stall.
  - id_is_jump is honoured only when id_valid=1 and stall=0.
  - If both occur in the same cycle, the branch wins (older instruction).
- Redirect effects, same cycle:
  - pc<=target.
  - IF/ID flushed: id_valid<=0, id_instruction<=0.
  - Skid buffer cleared; stall is overridden for the flush.
  - If a request is outstanding without ack this cycle: set drop, keep imem_addr unchanged until the ack, discard that ack, then request the target.
  - If ack arrives in the redirect cycle: discard it; the next request goes to the target.
- Halt detect: id_is_jump honoured, no mem_branch_taken, and id_jump_addr == id_pc_plus1-1. The result:
  - state<=HALT, halted<=1, flush as for a redirect;
  - an outstanding request is completed and discarded;
  - after that, imem_req=0 permanently and id_valid stays 0.
- Reset asserted mid-request: everything returns to reset values immediately. The memory must abandon the request.

Decomposition:
- Shared package lapido_defs.v: PC_WIDTH/INST_WIDTH defaults, NOP encoding (0), fetch state encodings BOOT/FETCH/HALT.
- One natural sub-module: lapido_fetch_skid, the 1-entry instruction+PC buffer with valid, load, unload and clear.
- Redirect mux, drop flag and FSM stay in the top block.

Test Plan:
- Reset release, 1-cycle memory returning addr+0x100: imem_addr 0,1,2,...; id_instruction 0x100,0x101,... one cycle after each ack; id_pc_plus1=addr+1; id_valid=1.
- 3-cycle memory latency: imem_addr held for 3 cycles per fetch, id_valid bubbles between instructions, no fetch skipped.
- stall=1 for 4 cycles while an ack lands at addr 5: imem_req drops, IF/ID unchanged; after stall falls, id_instruction=word 5 and fetch resumes at 6.
- id_is_jump to 0x20 with a request outstanding at 7: id_valid=0 next cycle, addr 7 held until ack and discarded, next imem_addr=0x20.
- Same cycle mem_branch_taken to 0x40 and id_is_jump to 0x20: next imem_addr=0x40.
- Jump to self (id_pc_plus1=0x11, id_jump_addr=0x10): halted=1, imem_req=0 after any pending ack, id_valid=0 held 10 cycles. Asserting rst=0 clears halted asynchronously, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/lapido_fetch_unit_pkg.sv
// Shared definitions for the LAPI DOpaCA LAMBA fetch stage.
// Holds the default bus widths, the NOP encoding and the fetch FSM state encoding.
package lapido_fetch_unit_pkg;

    localparam int unsigned DEF_PC_WIDTH   = 16;
    localparam int unsigned DEF_INST_WIDTH = 32;
    localparam int unsigned NOP_ENC        = 0;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/lapido_fetch_unit_if.sv
// Instruction memory request/acknowledge bus.
//   imem_req   : fetch request, held until acknowledged
//   imem_addr  : word address, stable while imem_req is high
//   imem_ack   : one-cycle data-valid strobe, only while imem_req is high
//   imem_rdata : instruction word, valid with imem_ack
// master = fetch unit, slave = instruction memory.
interface lapido_fetch_unit_if #(
    parameter int unsigned PC_WIDTH   = lapido_fetch_unit_pkg::DEF_PC_WIDTH,
    parameter int unsigned INST_WIDTH = lapido_fetch_unit_pkg::DEF_INST_WIDTH
) ();

    logic                  imem_req;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic                  imem_ack;
    logic [INST_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/lapido_fetch_unit_skid.sv
// One-entry holding buffer for an instruction that returns while ID is stalled.
//   load/load_*  : capture a new instruction and its PC+1
//   unload       : entry consumed by the IF/ID register
//   clear        : discard the entry (redirect); wins over load and unload
//   valid/instruction/pc_plus1 : registered buffer contents
module lapido_fetch_skid #(
    parameter int unsigned PC_WIDTH   = 16,
    parameter int unsigned INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  unload,
    input  logic                  clear,
    input  logic [INST_WIDTH-1:0] load_instruction,
    input  logic [PC_WIDTH-1:0]   load_pc_plus1,
    output logic                  valid,
    output logic [INST_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]   pc_plus1
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid       <= 1'b0;
            instruction <= '0;
            pc_plus1    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid       <= 1'b1;
            instruction <= load_instruction;
            pc_plus1    <= load_pc_plus1;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lapido_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches over the imem bus,
// loads the IF/ID register and applies stall, flush, redirect and halt.
//   clk, rst (async, active-low)
//   stall                             : ID hazard hold
//   mem_branch_taken/mem_branch_addr  : MEM-stage branch redirect (highest priority)
//   id_is_jump/id_jump_addr           : ID-stage jump redirect
//   imem                              : instruction memory bus (master side)
//   id_instruction/id_pc_plus1/id_valid : IF/ID pipeline register
//   halted                            : jump-to-self seen, fetching stopped
module lapido_fetch_unit
    import lapido_fetch_unit_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = DEF_PC_WIDTH,
    parameter int unsigned INST_WIDTH = DEF_INST_WIDTH,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  mem_branch_taken,
    input  logic [PC_WIDTH-1:0]   mem_branch_addr,
    input  logic                  id_is_jump,
    input  logic [PC_WIDTH-1:0]   id_jump_addr,
    lapido_fetch_unit_if.master   imem,
    output logic [INST_WIDTH-1:0] id_instruction,
    output logic [PC_WIDTH-1:0]   id_pc_plus1,
    output logic                  id_valid,
    output logic                  halted
);

    localparam logic [PC_WIDTH-1:0]   PC_RST = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0]   PC_ONE = PC_WIDTH'(1);
    localparam logic [INST_WIDTH-1:0] NOP    = INST_WIDTH'(NOP_ENC);

    fetch_state_e          state;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   addr_q;
    logic                  req_q;
    logic                  drop;

    logic                  skid_valid;
    logic [INST_WIDTH-1:0] skid_instruction;
    logic [PC_WIDTH-1:0]   skid_pc_plus1;

    logic                  in_fetch_c;
    logic                  ack_c;
    logic                  branch_c;
    logic                  jump_c;
    logic                  redirect_c;
    logic                  halt_c;
    logic [PC_WIDTH-1:0]   target_c;
    logic                  take_c;
    logic                  skid_load_c;
    logic                  skid_unload_c;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    // Redirect decode: branch is older than the jump in ID, so it wins.
    assign in_fetch_c    = (state == ST_FETCH);
    assign ack_c         = req_q & imem.imem_ack;
    assign branch_c      = in_fetch_c & mem_branch_taken;
    assign jump_c        = in_fetch_c & id_is_jump & id_valid & ~stall;
    assign redirect_c    = branch_c | jump_c;
    assign halt_c        = jump_c & ~branch_c & (id_jump_addr == (id_pc_plus1 - PC_ONE));
    assign target_c      = branch_c ? mem_branch_addr : id_jump_addr;

    // An ack is only kept when it is not stale (drop) and not flushed this cycle.
    assign take_c        = in_fetch_c & ack_c & ~drop & ~redirect_c;
    assign skid_load_c   = take_c & stall;
    assign skid_unload_c = in_fetch_c & skid_valid & ~stall & ~redirect_c;

    lapido_fetch_skid #(
        .PC_WIDTH   (PC_WIDTH),
        .INST_WIDTH (INST_WIDTH)
    ) u_skid (
        .clk              (clk),
        .rst_n            (rst),
        .load             (skid_load_c),
        .unload           (skid_unload_c),
        .clear            (redirect_c),
        .load_instruction (imem.imem_rdata),
        .load_pc_plus1    (addr_q + PC_ONE),
        .valid            (skid_valid),
        .instruction      (skid_instruction),
        .pc_plus1         (skid_pc_plus1)
    );

    // Fetch FSM, PC, request control and IF/ID register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_BOOT;
            pc             <= PC_RST;
            addr_q         <= PC_RST;
            req_q          <= 1'b0;
            drop           <= 1'b0;
            id_instruction <= NOP;
            id_pc_plus1    <= '0;
            id_valid       <= 1'b0;
            halted         <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state  <= ST_FETCH;
                    req_q  <= 1'b1;
                    addr_q <= pc;
                end

                ST_FETCH: begin
                    // IF/ID: flush beats stall; stall holds; otherwise load or bubble.
                    if (redirect_c) begin
                        id_valid       <= 1'b0;
                        id_instruction <= NOP;
                    end else if (skid_unload_c) begin
                        id_valid       <= 1'b1;
                        id_instruction <= skid_instruction;
                        id_pc_plus1    <= skid_pc_plus1;
                    end else if (take_c && !stall) begin
                        id_valid       <= 1'b1;
                        id_instruction <= imem.imem_rdata;
                        id_pc_plus1    <= addr_q + PC_ONE;
                    end else if (!stall) begin
                        id_valid <= 1'b0;
                    end

                    if (redirect_c) begin
                        pc <= target_c;
                    end else if (take_c) begin
                        pc <= pc + PC_ONE;
                    end

                    // Requests stay stable until acked; a redirect with one in
                    // flight marks it stale so its ack is thrown away.
                    if (ack_c) begin
                        drop <= 1'b0;
                        if (halt_c) begin
                            req_q <= 1'b0;
                        end else if (redirect_c) begin
                            req_q  <= 1'b1;
                            addr_q <= target_c;
                        end else if (drop) begin
                            req_q  <= 1'b1;
                            addr_q <= pc;
                        end else begin
                            req_q  <= ~stall;
                            addr_q <= pc + PC_ONE;
                        end
                    end else if (req_q) begin
                        if (redirect_c) begin
                            drop <= 1'b1;
                        end
                    end else if (redirect_c) begin
                        req_q  <= ~halt_c;
                        addr_q <= target_c;
                    end else if (skid_unload_c) begin
                        req_q  <= 1'b1;
                        addr_q <= pc;
                    end

                    if (halt_c) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end
                end

                ST_HALT: begin
                    // Finish off the last outstanding request, then stay idle.
                    if (ack_c) begin
                        req_q <= 1'b0;
                        drop  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lapido_fetch_unit.sv
// Directed bench for lapido_fetch_unit with a bus-level instruction memory
// that answers addr+0x100 after a programmable latency.
module tb_lapido_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        mem_branch_taken;
    logic [15:0] mem_branch_addr;
    logic        id_is_jump;
    logic [15:0] id_jump_addr;
    logic [31:0] id_instruction;
    logic [15:0] id_pc_plus1;
    logic        id_valid;
    logic        halted;

    int   n_pass   = 0;
    int   n_fail   = 0;
    int   n_checks = 0;
    int   lat      = 1;
    int   cnt      = 0;
    logic mem_hold = 1'b0;

    lapido_fetch_unit_if imem_bus ();

    lapido_fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .mem_branch_taken (mem_branch_taken),
        .mem_branch_addr  (mem_branch_addr),
        .id_is_jump       (id_is_jump),
        .id_jump_addr     (id_jump_addr),
        .imem             (imem_bus),
        .id_instruction   (id_instruction),
        .id_pc_plus1      (id_pc_plus1),
        .id_valid         (id_valid),
        .halted           (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle, then update the memory response from the settled request.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst || !imem_bus.imem_req) begin
            imem_bus.imem_ack = 1'b0;
            cnt = 0;
        end else if (!mem_hold && (cnt + 1 >= lat)) begin
            imem_bus.imem_ack   = 1'b1;
            imem_bus.imem_rdata = 32'(imem_bus.imem_addr) + 32'h100;
            cnt = 0;
        end else begin
            imem_bus.imem_ack = 1'b0;
            cnt = cnt + 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reset, release, and return in the first FETCH cycle (request to 0 on the bus).
    task automatic start(input int l);
        rst              = 1'b0;
        stall            = 1'b0;
        mem_branch_taken = 1'b0;
        mem_branch_addr  = '0;
        id_is_jump       = 1'b0;
        id_jump_addr     = '0;
        mem_hold         = 1'b0;
        lat              = l;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        rst                 = 1'b0;
        stall               = 1'b0;
        mem_branch_taken    = 1'b0;
        mem_branch_addr     = '0;
        id_is_jump          = 1'b0;
        id_jump_addr        = '0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = '0;

        // Reset values
        tick();
        tick();
        check("rst_req",   32'(imem_bus.imem_req), 32'd0);
        check("rst_addr",  32'(imem_bus.imem_addr), 32'd0);
        check("rst_instr", id_instruction, 32'd0);
        check("rst_pc1",   32'(id_pc_plus1), 32'd0);
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_halt",  32'(halted), 32'd0);

        // Single-cycle memory, back-to-back fetches
        start(1);
        check("t1_addr0", 32'(imem_bus.imem_addr), 32'd0);
        check("t1_req0",  32'(imem_bus.imem_req), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t1_addr%0d", i + 1), 32'(imem_bus.imem_addr), 32'(i + 1));
            check($sformatf("t1_instr%0d", i), id_instruction, 32'h100 + 32'(i));
            check($sformatf("t1_pc1_%0d", i), 32'(id_pc_plus1), 32'(i + 1));
            check($sformatf("t1_valid%0d", i), 32'(id_valid), 32'd1);
        end

        // Three-cycle memory: address held, bubbles between instructions
        start(3);
        for (int w = 0; w < 3; w++) begin
            for (int j = 0; j < 3; j++) begin
                check($sformatf("t2_addr_w%0d_j%0d", w, j), 32'(imem_bus.imem_addr), 32'(w));
                if (j == 0 && w > 0) begin
                    check($sformatf("t2_valid_w%0d", w), 32'(id_valid), 32'd1);
                    check($sformatf("t2_instr_w%0d", w), id_instruction, 32'h100 + 32'(w - 1));
                end
                if (j == 1) begin
                    check($sformatf("t2_bubble_w%0d", w), 32'(id_valid), 32'd0);
                end
                tick();
            end
        end

        // Stall while the ack for address 5 lands
        start(1);
        repeat (5) tick();
        check("t3_addr5", 32'(imem_bus.imem_addr), 32'd5);
        stall = 1'b1;
        tick();
        check("t3_req_drop",  32'(imem_bus.imem_req), 32'd0);
        check("t3_hold_inst", id_instruction, 32'h104);
        check("t3_hold_pc1",  32'(id_pc_plus1), 32'd5);
        check("t3_hold_vld",  32'(id_valid), 32'd1);
        tick();
        tick();
        check("t3_req_drop2",  32'(imem_bus.imem_req), 32'd0);
        check("t3_hold_inst2", id_instruction, 32'h104);
        tick();
        stall = 1'b0;
        check("t3_hold_inst3", id_instruction, 32'h104);
        tick();
        check("t3_skid_inst", id_instruction, 32'h105);
        check("t3_skid_pc1",  32'(id_pc_plus1), 32'd6);
        check("t3_skid_vld",  32'(id_valid), 32'd1);
        check("t3_resume_req",  32'(imem_bus.imem_req), 32'd1);
        check("t3_resume_addr", 32'(imem_bus.imem_addr), 32'd6);
        tick();
        check("t3_next_inst", id_instruction, 32'h106);

        // Jump with a request outstanding at address 7
        start(1);
        repeat (6) tick();
        mem_hold = 1'b1;
        tick();
        check("t4_addr7",  32'(imem_bus.imem_addr), 32'd7);
        check("t4_pc1",    32'(id_pc_plus1), 32'd7);
        check("t4_valid",  32'(id_valid), 32'd1);
        id_is_jump   = 1'b1;
        id_jump_addr = 16'h0020;
        tick();
        id_is_jump = 1'b0;
        check("t4_flush_vld",  32'(id_valid), 32'd0);
        check("t4_flush_inst", id_instruction, 32'd0);
        check("t4_hold_addr",  32'(imem_bus.imem_addr), 32'd7);
        check("t4_hold_req",   32'(imem_bus.imem_req), 32'd1);
        tick();
        check("t4_hold_addr2", 32'(imem_bus.imem_addr), 32'd7);
        mem_hold = 1'b0;
        tick();
        check("t4_ack_addr", 32'(imem_bus.imem_addr), 32'd7);
        tick();
        check("t4_target", 32'(imem_bus.imem_addr), 32'h20);
        check("t4_discard_vld", 32'(id_valid), 32'd0);
        tick();
        check("t4_tgt_inst", id_instruction, 32'h120);
        check("t4_tgt_pc1",  32'(id_pc_plus1), 32'h21);
        check("t4_tgt_vld",  32'(id_valid), 32'd1);

        // Branch and jump together: branch wins; then PC wrap; then branch under stall
        start(1);
        tick();
        check("t5_valid", 32'(id_valid), 32'd1);
        check("t5_addr1", 32'(imem_bus.imem_addr), 32'd1);
        mem_branch_taken = 1'b1;
        mem_branch_addr  = 16'h0040;
        id_is_jump       = 1'b1;
        id_jump_addr     = 16'h0020;
        tick();
        mem_branch_taken = 1'b0;
        id_is_jump       = 1'b0;
        check("t5_br_wins",  32'(imem_bus.imem_addr), 32'h40);
        check("t5_br_flush", 32'(id_valid), 32'd0);
        check("t5_no_halt",  32'(halted), 32'd0);
        tick();
        check("t5_br_inst", id_instruction, 32'h140);
        check("t5_br_pc1",  32'(id_pc_plus1), 32'h41);
        mem_branch_taken = 1'b1;
        mem_branch_addr  = 16'hFFFF;
        tick();
        mem_branch_taken = 1'b0;
        check("t5_addr_ffff", 32'(imem_bus.imem_addr), 32'hFFFF);
        tick();
        check("t5_wrap_inst", id_instruction, 32'h0001_00FF);
        check("t5_wrap_pc1",  32'(id_pc_plus1), 32'd0);
        check("t5_wrap_addr", 32'(imem_bus.imem_addr), 32'd0);
        stall            = 1'b1;
        mem_branch_taken = 1'b1;
        mem_branch_addr  = 16'h0030;
        tick();
        mem_branch_taken = 1'b0;
        check("t5_stbr_vld",  32'(id_valid), 32'd0);
        check("t5_stbr_inst", id_instruction, 32'd0);
        check("t5_stbr_addr", 32'(imem_bus.imem_addr), 32'h30);
        tick();
        check("t5_stbr_req", 32'(imem_bus.imem_req), 32'd0);
        check("t5_stbr_vld2", 32'(id_valid), 32'd0);
        stall = 1'b0;
        tick();
        check("t5_stbr_inst2", id_instruction, 32'h130);
        check("t5_stbr_pc1",   32'(id_pc_plus1), 32'h31);

        // Jump to self halts; reset restarts fetching
        start(1);
        mem_branch_taken = 1'b1;
        mem_branch_addr  = 16'h0010;
        tick();
        mem_branch_taken = 1'b0;
        check("t6_addr10", 32'(imem_bus.imem_addr), 32'h10);
        mem_hold = 1'b1;
        tick();
        check("t6_pc1",   32'(id_pc_plus1), 32'h11);
        check("t6_valid", 32'(id_valid), 32'd1);
        id_is_jump   = 1'b1;
        id_jump_addr = 16'h0010;
        tick();
        id_is_jump = 1'b0;
        check("t6_halted",  32'(halted), 32'd1);
        check("t6_flush",   32'(id_valid), 32'd0);
        check("t6_pend_req", 32'(imem_bus.imem_req), 32'd1);
        check("t6_pend_addr", 32'(imem_bus.imem_addr), 32'h11);
        mem_hold = 1'b0;
        tick();
        check("t6_ack_req", 32'(imem_bus.imem_req), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("t6_idle_vld%0d", i), 32'(id_valid), 32'd0);
            check($sformatf("t6_idle_req%0d", i), 32'(imem_bus.imem_req), 32'd0);
            check($sformatf("t6_idle_hlt%0d", i), 32'(halted), 32'd1);
        end
        rst = 1'b0;
        #2;
        check("t6_async_hlt",  32'(halted), 32'd0);
        check("t6_async_addr", 32'(imem_bus.imem_addr), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("t6_restart_addr", 32'(imem_bus.imem_addr), 32'd0);
        check("t6_restart_req",  32'(imem_bus.imem_req), 32'd1);
        tick();
        check("t6_restart_inst", id_instruction, 32'h100);
        check("t6_restart_vld",  32'(id_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
